// File: rtl/ternary_defs.sv
// Shared ternary encodings and widths for the data-memory path.
// Trit i of a vector occupies bits [2*i +: 2]; trit 0 is least significant.
package ternary_defs;
  localparam int TRIT_WIDTH = 27;
  localparam int ADDR_TRITS = 9;
  localparam int TRIT_BITS  = 2;

  typedef enum logic [1:0] {
    T_ZERO    = 2'b00,
    T_POS_ONE = 2'b01,
    T_NEG_ONE = 2'b10
  } trit_e;

  // The 2'b11 code is undefined and contributes zero.
  function automatic logic signed [1:0] trit_val(input logic [1:0] t);
    case (t)
      T_POS_ONE: trit_val = 2'sb01;
      T_NEG_ONE: trit_val = 2'sb11;
      default:   trit_val = 2'sb00;
    endcase
  endfunction
endpackage

// File: rtl/ternary_addr_check.sv
// Balanced-ternary address decode: signed word index plus range check
// against 0..DMEM_DEPTH-1.
module ternary_addr_check
  import ternary_defs::*;
#(
  parameter int N_TRITS    = ADDR_TRITS,
  parameter int DMEM_DEPTH = 729,
  parameter int IDX_W      = $clog2(3**N_TRITS) + 1
) (
  input  logic [N_TRITS*TRIT_BITS-1:0] addr,
  output logic signed [IDX_W-1:0]      idx,
  output logic                         in_range
);
  logic signed [IDX_W-1:0] acc;

  // Horner evaluation from the most significant trit down: acc = 3*acc + t.
  always_comb begin
    acc = '0;
    for (int i = N_TRITS - 1; i >= 0; i--)
      acc = (acc <<< 1) + acc + IDX_W'(trit_val(addr[i*TRIT_BITS +: TRIT_BITS]));
  end

  assign idx      = acc;
  assign in_range = !acc[IDX_W-1] && (acc < $signed(IDX_W'(DMEM_DEPTH)));
endmodule

// File: rtl/ternary_dmem_arbiter.sv
// Round-robin two-port arbiter for the ternary data memory port.
// Optional grant locking for atomic sequences: define DMEM_ARB_LOCK_EN.
module ternary_dmem_arbiter #(
  parameter int TRIT_WIDTH = ternary_defs::TRIT_WIDTH,
  parameter int ADDR_TRITS = ternary_defs::ADDR_TRITS,
  parameter int DMEM_DEPTH = 729,
  parameter int LOCK_MAX   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  logic [1:0]                req_we,
  input  logic [2*ADDR_TRITS*2-1:0] req_addr,
  input  logic [2*TRIT_WIDTH*2-1:0] req_wdata,
  input  logic [1:0]                req_lock,
  output logic [1:0]                rsp_valid,
  output logic [TRIT_WIDTH*2-1:0]   rsp_rdata,
  output logic                      rsp_err,
  output logic [ADDR_TRITS*2-1:0]   dmem_addr,
  output logic [TRIT_WIDTH*2-1:0]   dmem_wdata,
  output logic                      dmem_we,
  output logic                      dmem_re,
  input  logic [TRIT_WIDTH*2-1:0]   dmem_rdata
);
  import ternary_defs::*;

  localparam int AW    = ADDR_TRITS * TRIT_BITS;
  localparam int DW    = TRIT_WIDTH * TRIT_BITS;
  localparam int IDX_W = $clog2(3**ADDR_TRITS) + 1;

  logic [1:0][AW-1:0]    addr_a;
  logic [1:0][DW-1:0]    wdata_a;
  logic [1:0][IDX_W-1:0] unused_idx;
  logic [1:0]            rng;
  logic [1:0]            gnt;
  logic                  gsel, acc, sel_rng, sel_we;

  logic          rr_ptr_q, rr_ptr_d;
  logic [1:0]    rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;

  assign addr_a  = req_addr;
  assign wdata_a = req_wdata;

  for (genvar p = 0; p < 2; p++) begin : g_chk
    ternary_addr_check #(.N_TRITS(ADDR_TRITS), .DMEM_DEPTH(DMEM_DEPTH), .IDX_W(IDX_W)) u_chk (
      .addr(addr_a[p]), .idx(unused_idx[p]), .in_range(rng[p])
    );
  end

`ifdef DMEM_ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_MAX + 1);
  logic          lock_q, lock_d, lock_own_q, lock_own_d, lock_hold;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;

  assign lock_hold = lock_q && req_valid[lock_own_q] && req_lock[lock_own_q];

  // lock_cnt counts grants in the current locked run, including the first.
  always_comb begin
    lock_d     = 1'b0;
    lock_own_d = lock_own_q;
    lock_cnt_d = '0;
    if (acc && req_lock[gsel]) begin
      lock_own_d = gsel;
      lock_cnt_d = lock_hold ? lock_cnt_q + 1'b1 : CW'(1);
      lock_d     = lock_cnt_d < CW'(LOCK_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q     <= 1'b0;
      lock_own_q <= 1'b0;
      lock_cnt_q <= '0;
    end else begin
      lock_q     <= lock_d;
      lock_own_q <= lock_own_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end
`else
  logic unused_lock;
  localparam int unused_lock_max = LOCK_MAX;
  assign unused_lock = ^req_lock;
`endif

  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      if (&req_valid) gnt = rr_ptr_q ? 2'b10 : 2'b01;
      else            gnt = req_valid;
`ifdef DMEM_ARB_LOCK_EN
      if (lock_hold)  gnt = lock_own_q ? 2'b10 : 2'b01;
`endif
    end
  end

  assign gsel    = gnt[1];
  assign acc     = |gnt;
  assign sel_rng = rng[gsel];
  assign sel_we  = req_we[gsel];

  assign req_ready  = gnt;
  assign dmem_addr  = acc ? addr_a[gsel]  : '0;
  assign dmem_wdata = acc ? wdata_a[gsel] : '0;
  assign dmem_we    = acc &  sel_we & sel_rng;
  assign dmem_re    = acc & ~sel_we & sel_rng;

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    if (acc) rr_ptr_d = ~gsel;
    rsp_valid_d = gnt;
    rsp_err_d   = acc & ~sel_rng;
    rsp_rdata_d = dmem_re ? dmem_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_ternary_dmem_arbiter.sv
// Directed bench for ternary_dmem_arbiter with a behavioural 729-word memory.
module tb_ternary_dmem_arbiter;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   req_valid = '0, req_ready, req_we = '0, req_lock = '0, rsp_valid;
  logic [35:0]  req_addr = '0;
  logic [107:0] req_wdata = '0;
  logic [53:0]  rsp_rdata, dmem_wdata, dmem_rdata;
  logic         rsp_err, dmem_we, dmem_re;
  logic [17:0]  dmem_addr;

  int errors = 0;
  int checks = 0;

  localparam logic [17:0] A_P5    = 18'h0001A; // +5
  localparam logic [17:0] A_P6    = 18'h00018; // +6
  localparam logic [17:0] A_P6U   = 18'h0001B; // +6 with an undefined trit 0
  localparam logic [17:0] A_M1    = 18'h00002; // -1
  localparam logic [17:0] A_P728  = 18'h01002; // +728
  localparam logic [17:0] A_P729  = 18'h01000; // +729
  localparam logic [53:0] D_A     = 54'h0123456789ABC;
  localparam logic [53:0] D_B     = 54'h00000000ABCDE;

  always #5 clk = ~clk;

  ternary_dmem_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_lock(req_lock), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_we(dmem_we), .dmem_re(dmem_re), .dmem_rdata(dmem_rdata)
  );

  function automatic int tdec(input logic [17:0] a);
    int v = 0;
    for (int i = 8; i >= 0; i--) begin
      case (a[2*i +: 2])
        2'b01:   v = v * 3 + 1;
        2'b10:   v = v * 3 - 1;
        default: v = v * 3;
      endcase
    end
    return v;
  endfunction

  logic [53:0] mem [0:728];
  int ridx, widx;
  always_comb begin
    ridx = tdec(dmem_addr);
    dmem_rdata = (ridx >= 0 && ridx < 729) ? mem[ridx] : 54'h2AAAAAAAAAAAAA;
  end
  always @(posedge clk) begin
    widx = tdec(dmem_addr);
    if (dmem_we && widx >= 0 && widx < 729) mem[widx] <= dmem_wdata;
  end

  task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic [17:0] a0,
                       input logic [17:0] a1, input logic [53:0] w0, input logic [53:0] w1);
    req_valid = v; req_we = we; req_addr = {a1, a0}; req_wdata = {w1, w0};
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; drive(2'b00, 2'b00, '0, '0, '0, '0);
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    drive(2'b11, 2'b11, A_P5, A_P6, 54'h1, 54'h2);
    repeat (2) @(negedge clk);
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", req_ready); end
    checks++; if (dmem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", dmem_we); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
    checks++; if (rsp_rdata !== '0 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL reset_rsp_data: got %h/%b expected 0/0", rsp_rdata, rsp_err);
    end
    @(negedge clk); rst = 1'b0; drive(2'b00, 2'b00, '0, '0, '0, '0);
  endtask

  task automatic test_write_read();
    @(negedge clk); drive(2'b01, 2'b01, A_P5, '0, 54'h15, '0); #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL wr_ready: got %b expected 01", req_ready); end
    checks++; if (dmem_we !== 1'b1 || dmem_re !== 1'b0) begin
      errors++; $display("FAIL wr_strobes: got we=%b re=%b expected we=1 re=0", dmem_we, dmem_re);
    end
    checks++; if (dmem_addr !== A_P5 || dmem_wdata !== 54'h15) begin
      errors++; $display("FAIL wr_bus: got %h/%h expected %h/15", dmem_addr, dmem_wdata, A_P5);
    end
    @(negedge clk); drive(2'b01, 2'b00, A_P5, '0, '0, '0); #1;
    checks++; if (dmem_re !== 1'b1 || dmem_we !== 1'b0) begin
      errors++; $display("FAIL rd_strobes: got we=%b re=%b expected we=0 re=1", dmem_we, dmem_re);
    end
    checks++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b0 || rsp_rdata !== '0) begin
      errors++; $display("FAIL wr_rsp: got v=%b e=%b d=%h expected 01/0/0", rsp_valid, rsp_err, rsp_rdata);
    end
    @(negedge clk); drive(2'b00, 2'b00, '0, '0, '0, '0); #1;
    checks++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b0 || rsp_rdata !== 54'h15) begin
      errors++; $display("FAIL rd_rsp: got v=%b e=%b d=%h expected 01/0/15", rsp_valid, rsp_err, rsp_rdata);
    end
    checks++; if (dmem_addr !== '0 || dmem_we !== 1'b0 || dmem_re !== 1'b0) begin
      errors++; $display("FAIL idle_bus: got a=%h we=%b re=%b expected 0/0/0", dmem_addr, dmem_we, dmem_re);
    end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rsp_pulse: got %b expected 00", rsp_valid); end
  endtask

  task automatic test_boundary();
    @(negedge clk); drive(2'b10, 2'b10, '0, A_P728, '0, D_A); #1;
    checks++; if (req_ready !== 2'b10 || dmem_we !== 1'b1) begin
      errors++; $display("FAIL wr728: got rdy=%b we=%b expected 10/1", req_ready, dmem_we);
    end
    @(negedge clk); drive(2'b10, 2'b10, '0, A_P6, '0, D_B); #1;
    checks++; if (dmem_we !== 1'b1) begin errors++; $display("FAIL wr6: got we=%b expected 1", dmem_we); end
    @(negedge clk); drive(2'b10, 2'b00, '0, A_P728, '0, '0);
    @(negedge clk); drive(2'b10, 2'b00, '0, A_P6U, '0, '0); #1;
    checks++; if (rsp_valid !== 2'b10 || rsp_err !== 1'b0 || rsp_rdata !== D_A) begin
      errors++; $display("FAIL rd728: got v=%b e=%b d=%h expected 10/0/%h", rsp_valid, rsp_err, rsp_rdata, D_A);
    end
    @(negedge clk); drive(2'b00, 2'b00, '0, '0, '0, '0); #1;
    checks++; if (rsp_valid !== 2'b10 || rsp_err !== 1'b0 || rsp_rdata !== D_B) begin
      errors++; $display("FAIL rd_undef_trit: got v=%b e=%b d=%h expected 10/0/%h", rsp_valid, rsp_err, rsp_rdata, D_B);
    end
  endtask

  task automatic test_error();
    @(negedge clk); drive(2'b10, 2'b00, '0, A_M1, '0, '0); #1;
    checks++; if (req_ready !== 2'b10 || dmem_re !== 1'b0 || dmem_we !== 1'b0) begin
      errors++; $display("FAIL err_m1_bus: got rdy=%b re=%b we=%b expected 10/0/0", req_ready, dmem_re, dmem_we);
    end
    @(negedge clk); drive(2'b10, 2'b00, '0, A_P729, '0, '0); #1;
    checks++; if (rsp_valid !== 2'b10 || rsp_err !== 1'b1 || rsp_rdata !== '0) begin
      errors++; $display("FAIL err_m1_rsp: got v=%b e=%b d=%h expected 10/1/0", rsp_valid, rsp_err, rsp_rdata);
    end
    checks++; if (dmem_re !== 1'b0) begin errors++; $display("FAIL err_729_re: got %b expected 0", dmem_re); end
    @(negedge clk); drive(2'b10, 2'b10, '0, A_M1, '0, D_A); #1;
    checks++; if (rsp_valid !== 2'b10 || rsp_err !== 1'b1 || rsp_rdata !== '0) begin
      errors++; $display("FAIL err_729_rsp: got v=%b e=%b d=%h expected 10/1/0", rsp_valid, rsp_err, rsp_rdata);
    end
    checks++; if (dmem_we !== 1'b0) begin errors++; $display("FAIL err_wr_we: got %b expected 0", dmem_we); end
    @(negedge clk); drive(2'b00, 2'b00, '0, '0, '0, '0); #1;
    checks++; if (rsp_valid !== 2'b10 || rsp_err !== 1'b1) begin
      errors++; $display("FAIL err_wr_rsp: got v=%b e=%b expected 10/1", rsp_valid, rsp_err);
    end
  endtask

  task automatic test_contention();
    int cnt0 = 0, cnt1 = 0;
    logic [1:0] exp;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      if (c > 0) @(negedge clk);
      cnt0 += int'(rsp_valid[0]); cnt1 += int'(rsp_valid[1]);
      if (c < 6) drive(2'b11, 2'b00, A_P5, A_P6, '0, '0);
      else       drive(2'b00, 2'b00, '0, '0, '0, '0);
      #1;
      if (c < 6) begin
        exp = (c % 2 == 0) ? 2'b01 : 2'b10;
        checks++; if (req_ready !== exp) begin errors++; $display("FAIL rr_cycle%0d: got %b expected %b", c, req_ready, exp); end
      end
    end
    checks++; if (cnt0 != 3 || cnt1 != 3) begin errors++; $display("FAIL rr_counts: got %0d/%0d expected 3/3", cnt0, cnt1); end
  endtask

  task automatic test_single_port();
    int cnt0 = 0, cnt1 = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      cnt0 += int'(rsp_valid[0]); cnt1 += int'(rsp_valid[1]);
      if (c < 4) drive(2'b10, 2'b00, '0, (c % 2 == 0) ? A_P5 : A_P6, '0, '0);
      else       drive(2'b00, 2'b00, '0, '0, '0, '0);
      #1;
      if (c < 4) begin
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL solo_cycle%0d: got %b expected 10", c, req_ready); end
      end
    end
    checks++; if (cnt0 != 0 || cnt1 != 4) begin errors++; $display("FAIL solo_counts: got %0d/%0d expected 0/4", cnt0, cnt1); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); drive(2'b01, 2'b00, A_P5, '0, '0, '0);
    @(negedge clk); rst = 1'b1; drive(2'b11, 2'b10, A_P5, A_P6, '0, 54'hBAD); #1;
    checks++; if (req_ready !== 2'b00 || dmem_we !== 1'b0) begin
      errors++; $display("FAIL rstmid_gate: got rdy=%b we=%b expected 00/0", req_ready, dmem_we);
    end
    @(negedge clk); rst = 1'b0;
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rstmid_drop: got %b expected 00", rsp_valid); end
    drive(2'b11, 2'b00, A_P5, A_P6, '0, '0); #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rstmid_rrptr: got %b expected 01", req_ready); end
    @(negedge clk); drive(2'b00, 2'b00, '0, '0, '0, '0); #1;
    checks++; if (rsp_valid !== 2'b01 || rsp_rdata !== 54'h15) begin
      errors++; $display("FAIL rstmid_rd: got v=%b d=%h expected 01/15", rsp_valid, rsp_rdata);
    end
    @(negedge clk); drive(2'b10, 2'b00, '0, A_P6, '0, '0);
    @(negedge clk); drive(2'b00, 2'b00, '0, '0, '0, '0); #1;
    checks++; if (rsp_rdata !== D_B) begin errors++; $display("FAIL rstmid_nowrite: got %h expected %h", rsp_rdata, D_B); end
  endtask

  task automatic test_lock();
    logic [1:0] exp;
    do_reset();
    req_lock = 2'b01;
    for (int c = 0; c < 17; c++) begin
      if (c > 0) @(negedge clk);
      drive(2'b11, 2'b00, A_P5, A_P6, '0, '0); #1;
`ifdef DMEM_ARB_LOCK_EN
      exp = (c < 16) ? 2'b01 : 2'b10;
`else
      exp = (c % 2 == 0) ? 2'b01 : 2'b10;
`endif
      checks++; if (req_ready !== exp) begin errors++; $display("FAIL lock_cycle%0d: got %b expected %b", c, req_ready, exp); end
    end
    @(negedge clk); req_lock = 2'b00; drive(2'b00, 2'b00, '0, '0, '0, '0);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_boundary();
    test_error();
    test_contention();
    test_single_port();
    test_reset_mid();
    test_lock();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
